// File: rtl/dense_neuron_mac_if.sv
// rtl/dense_neuron_mac_if.sv - pair stream, start/bias and result bus of the dense neuron MAC
interface dense_neuron_mac_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32
);
  logic                       start;
  logic signed [2*DATA_W-1:0] bias;
  logic                       in_valid;
  logic                       in_ready;
  logic signed [DATA_W-1:0]   x;
  logic signed [DATA_W-1:0]   w;
  logic signed [OUT_W-1:0]    out_data;
  logic                       out_ld;
  logic                       busy;
  logic                       sat;

  modport master (
    output start, bias, in_valid, x, w,
    input  in_ready, out_data, out_ld, busy, sat
  );

  modport slave (
    input  start, bias, in_valid, x, w,
    output in_ready, out_data, out_ld, busy, sat
  );
endinterface

// File: rtl/dense_neuron_mac.sv
// rtl/dense_neuron_mac.sv - single-neuron MAC: bias + sum(x*w), rescale, saturate
// Optional ReLU on the result when DENSE_MAC_RELU_EN is defined.
module dense_neuron_mac #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int N_IN   = 784,
  parameter int OUT_W  = 32,
  parameter int CNT_W  = $clog2(N_IN + 1)
) (
  input logic               clk,
  input logic               rst,
  dense_neuron_mac_if.slave bus
);
  localparam int ACC_W = 2*DATA_W + $clog2(N_IN) + 1;
  localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_IN - 1);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t                     state_q, state_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic signed [OUT_W-1:0]    out_data_q, out_data_d;
  logic                       out_ld_q, out_ld_d;
  logic                       sat_q, sat_d;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    r_shift;
  logic signed [EXT_W-1:0]    r_ext;
  logic [EXT_W-OUT_W:0]       r_top;
  logic                       ovf_pos, ovf_neg;
  logic signed [OUT_W-1:0]    r_clip;

  assign prod    = (2*DATA_W)'(bus.x) * (2*DATA_W)'(bus.w);
  assign r_shift = acc_q >>> FRAC_W;
  assign r_ext   = EXT_W'(r_shift);
  // The result fits OUT_W only if every bit from OUT_W-1 upward equals the sign.
  assign r_top   = r_ext[EXT_W-1:OUT_W-1];
  assign ovf_pos = !r_ext[EXT_W-1] && (|r_top);
  assign ovf_neg = r_ext[EXT_W-1] && !(&r_top);

  always_comb begin
    r_clip = r_ext[OUT_W-1:0];
    if (ovf_pos) begin
      r_clip = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (ovf_neg) begin
      r_clip = {1'b1, {(OUT_W-1){1'b0}}};
    end
`ifdef DENSE_MAC_RELU_EN
    if (r_clip[OUT_W-1]) begin
      r_clip = '0;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    sat_d      = sat_q;
    out_ld_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = ACC_W'(bus.bias);
          cnt_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        if (bus.in_valid) begin
          acc_d = acc_q + ACC_W'(prod);
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = OUT;
          end
        end
      end
      OUT: begin
        out_data_d = r_clip;
        sat_d      = ovf_pos || ovf_neg;
        out_ld_d   = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_ld_q   <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_ld_q   <= out_ld_d;
      sat_q      <= sat_d;
    end
  end

  assign bus.in_ready = (state_q == ACC);
  assign bus.busy     = (state_q != IDLE);
  assign bus.out_data = out_data_q;
  assign bus.out_ld   = out_ld_q;
  assign bus.sat      = sat_q;
endmodule

// File: tb/tb_dense_neuron_mac.sv
// tb/tb_dense_neuron_mac.sv - scoreboard bench for dense_neuron_mac (three parameter sets)
module tb_dense_neuron_mac;
  typedef struct {
    longint d;
    bit     s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  start_v;
  logic [31:0] tb_bias;
  logic [15:0] tb_x, tb_w;
  logic        tb_valid;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        q_a[$], q_b[$], q_c[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dense_neuron_mac_if #(.DATA_W(16), .OUT_W(32)) if_a ();
  dense_neuron_mac_if #(.DATA_W(16), .OUT_W(16)) if_b ();
  dense_neuron_mac_if #(.DATA_W(16), .OUT_W(32)) if_c ();

  assign if_a.start = start_v[0];
  assign if_b.start = start_v[1];
  assign if_c.start = start_v[2];
  assign if_a.bias = tb_bias;
  assign if_b.bias = tb_bias;
  assign if_c.bias = tb_bias;
  assign if_a.x = tb_x;
  assign if_b.x = tb_x;
  assign if_c.x = tb_x;
  assign if_a.w = tb_w;
  assign if_b.w = tb_w;
  assign if_c.w = tb_w;
  assign if_a.in_valid = tb_valid;
  assign if_b.in_valid = tb_valid;
  assign if_c.in_valid = tb_valid;

  dense_neuron_mac #(.DATA_W(16), .FRAC_W(8), .N_IN(4), .OUT_W(32)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  dense_neuron_mac #(.DATA_W(16), .FRAC_W(8), .N_IN(4), .OUT_W(16)) u_b (.clk(clk), .rst(rst), .bus(if_b));
  dense_neuron_mac #(.DATA_W(16), .FRAC_W(8), .N_IN(1), .OUT_W(32)) u_c (.clk(clk), .rst(rst), .bus(if_c));

  task automatic check_val(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sat_model(input longint acc, input int out_w, output bit s);
    longint r, mx, mn;
    r  = acc >>> 8;
    mx = (longint'(1) <<< (out_w - 1)) - 1;
    mn = -(longint'(1) <<< (out_w - 1));
    s  = 1'b0;
    if (r > mx) begin
      r = mx;
      s = 1'b1;
    end else if (r < mn) begin
      r = mn;
      s = 1'b1;
    end
`ifdef DENSE_MAC_RELU_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  function automatic logic rdy(input int sel);
    return (sel == 0) ? if_a.in_ready : (sel == 1) ? if_b.in_ready : if_c.in_ready;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? if_a.busy : (sel == 1) ? if_b.busy : if_c.busy;
  endfunction

  function automatic logic ld_of(input int sel);
    return (sel == 0) ? if_a.out_ld : (sel == 1) ? if_b.out_ld : if_c.out_ld;
  endfunction

  task automatic pop_check(input int sel, input logic signed [63:0] d, input logic s);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (sel == 0 && q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
    if (sel == 1 && q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
    if (sel == 2 && q_c.size() > 0) begin e = q_c.pop_front(); have = 1'b1; end
    if (!have) begin
      check_val($sformatf("dut%0d_unexpected_out_ld", sel), 1, 0);
    end else begin
      check_val($sformatf("dut%0d_out_data", sel), d, e.d);
      check_val($sformatf("dut%0d_sat", sel), s, e.s);
    end
  endtask

  always @(negedge clk) begin
    if (if_a.out_ld === 1'b1) pop_check(0, $signed(if_a.out_data), if_a.sat);
    if (if_b.out_ld === 1'b1) pop_check(1, $signed(if_b.out_data), if_b.sat);
    if (if_c.out_ld === 1'b1) pop_check(2, $signed(if_c.out_data), if_c.sat);
  end

  // One neuron on DUT sel; abort_at>0 returns after that many pairs without pushing a result.
  task automatic run(input int sel, input longint bias, input int x, input int w, input bit gaps,
                     input bit chk_lat, input bit mid_start, input int abort_at);
    int     n, sent, t, c0;
    bit     found, s;
    exp_t   e;
    longint acc;
    n     = (sel == 2) ? 1 : 4;
    acc   = bias + longint'(n) * longint'(x) * longint'(w);
    e.d   = sat_model(acc, (sel == 1) ? 16 : 32, s);
    e.s   = s;
    if (abort_at == 0) begin
      if (sel == 0) q_a.push_back(e);
      if (sel == 1) q_b.push_back(e);
      if (sel == 2) q_c.push_back(e);
    end
    tb_bias = bias[31:0];
    tb_x = x[15:0];
    tb_w = w[15:0];
    start_v[sel] = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start_v[sel] = 1'b0;
    sent = 0;
    t = 0;
    while (sent < n && t < 64) begin
      if (abort_at != 0 && sent == abort_at) begin
        tb_valid = 1'b0;
        return;
      end
      tb_valid = gaps ? (t % 2 == 0) : 1'b1;
      if (mid_start && t == 2) begin
        start_v[sel] = 1'b1;
        tb_bias = 32'h4000_0000;
      end else begin
        start_v[sel] = 1'b0;
      end
      if (tb_valid && rdy(sel)) sent++;
      @(negedge clk);
      t++;
    end
    start_v[sel] = 1'b0;
    if (sent < n) begin
      check_val("pair_timeout", sent, n);
      tb_valid = 1'b0;
      return;
    end
    tb_valid = 1'b1;
    check_val("in_ready_in_out", rdy(sel), 0);
    check_val("busy_in_out", busy_of(sel), 1);
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge clk);
      found = ld_of(sel);
    end
    if (!found) begin
      check_val("out_ld_timeout", 0, 1);
    end else begin
      if (chk_lat) check_val("latency", cyc - c0, n + 2);
      check_val("in_ready_after_out", rdy(sel), 0);
    end
    tb_valid = 1'b0;
    @(negedge clk);
    check_val("busy_idle", busy_of(sel), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    start_v = '0;
    tb_bias = '0;
    tb_x = '0;
    tb_w = '0;
    tb_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_out_data", if_a.out_data, 0);
    check_val("rst_out_ld", if_a.out_ld, 0);
    check_val("rst_busy", if_a.busy, 0);
    check_val("rst_in_ready", if_a.in_ready, 0);
    check_val("rst_sat", if_a.sat, 0);
    rst = 1'b1;
    @(negedge clk);

    run(0, 0, 256, 512, 1'b0, 1'b1, 1'b0, 0);
    run(0, 0, 256, 512, 1'b1, 1'b0, 1'b0, 0);
    run(0, 0, -256, 512, 1'b0, 1'b1, 1'b0, 0);
    run(1, 0, 32767, 32767, 1'b0, 1'b1, 1'b0, 0);
    run(1, 0, -32768, 32767, 1'b0, 1'b0, 1'b0, 0);
    run(1, 0, 256, 512, 1'b0, 1'b0, 1'b0, 0);
    run(2, 65536, 0, 0, 1'b0, 1'b1, 1'b0, 0);
    run(2, 0, 256, 256, 1'b0, 1'b0, 1'b0, 0);
    run(0, 0, 300, -700, 1'b0, 1'b0, 1'b1, 0);

    run(0, 0, 256, 256, 1'b0, 1'b0, 1'b0, 2);
    rst = 1'b0;
    #1;
    check_val("midrst_out_data", if_a.out_data, 0);
    check_val("midrst_out_ld", if_a.out_ld, 0);
    check_val("midrst_busy", if_a.busy, 0);
    check_val("midrst_in_ready", if_a.in_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run(0, 0, 256, 256, 1'b0, 1'b1, 1'b0, 0);

    repeat (3) @(negedge clk);
    check_val("dut0_pending", q_a.size(), 0);
    check_val("dut1_pending", q_b.size(), 0);
    check_val("dut2_pending", q_c.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dense_neuron_mac.md
Name: dense_neuron_mac

Overview:
Single-neuron multiply-accumulate engine for the dense layer. It consumes a stream of (activation, weight) pairs, adds a bias, then rescales and saturates the sum. It sits directly upstream of the dense-layer 32-bit output register and drives that register's data and load inputs. The dense controller starts one neuron at a time.

Parameters:
DATA_W, 16, signed activation and weight width, fixed-point with FRAC_W fraction bits.
FRAC_W, 8, fraction bits of activations, weights and outputs (Q(DATA_W-FRAC_W).FRAC_W).
N_IN, 784, number of input pairs per neuron (must be >= 1).
OUT_W, 32, signed output width; matches the downstream register SIZE.
CNT_W, $clog2(N_IN+1), width of the pair counter.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low (asserted when 0)
start  input  1  one-cycle pulse; begins a neuron computation; ignored unless state is IDLE
bias  input  2*DATA_W  signed bias in product scale (2*FRAC_W fraction bits); sampled on accepted start
in_valid  input  1  x/w pair valid
in_ready  output  1  block accepts a pair this cycle
x  input  DATA_W  signed activation
w  input  DATA_W  signed weight
out_data  output  OUT_W  signed rescaled, saturated neuron result; held until next result
out_ld  output  1  one-cycle pulse; wire to downstream register ld
busy  output  1  high in any state other than IDLE
sat  output  1  high with out_ld when the result was clipped; held until next out_ld

Behaviour:
- Reset (rst=0, async): state=IDLE, acc=0, count=0, out_data=0, out_ld=0, in_ready=0, busy=0, sat=0. A reset mid-computation discards all partial state. The first start after reset begins a fresh computation.
- Internal accumulator width is ACC_W = 2*DATA_W + $clog2(N_IN) + 1, signed. Products are full 2*DATA_W signed and sign-extended into acc. The accumulator never wraps for legal N_IN.
- FSM states:
  - IDLE: in_ready=0. On start=1, acc <= sign-extended bias, count <= 0, go to ACC.
  - ACC: in_ready=1. On in_valid&&in_ready, acc <= acc + x*w and count <= count+1. When the accepted pair is pair number N_IN (count == N_IN-1), go to OUT. Cycles with in_valid=0 change nothing. in_ready drops in the cycle the FSM is in OUT, so pair N_IN+1 is never accepted.
  - OUT (one cycle): compute r = acc >>> FRAC_W (arithmetic shift). If r > 2^(OUT_W-1)-1, out_data=max and sat=1. If r < -2^(OUT_W-1), out_data=min and sat=1. Otherwise out_data=r[OUT_W-1:0] and sat=0. out_data, sat and out_ld=1 are registered together. Go to IDLE.
- Latency: out_ld is asserted exactly 1 cycle after the clock edge accepting the last pair. With in_valid held high, this is N_IN+2 cycles from start.
- start during ACC or OUT is ignored; it is not queued.
- in_valid in IDLE is ignored and no pair is consumed.
- Rounding is truncation toward -infinity (from the arithmetic shift).

Optional Feature:
Macro DENSE_MAC_RELU_EN.
- Defined: ReLU is applied in OUT after saturation. A negative result gives out_data=0. sat still reports clipping at the negative bound.
- Undefined: out_data is the signed saturated result, with no ReLU logic.

Test Plan:
1. N_IN=4, bias=0, four pairs x=256, w=512 (1.0*2.0), in_valid held -> out_ld pulse 6 cycles after start, out_data=2048, sat=0.
2. Same stream, but in_valid low on alternate cycles -> only valid cycles are counted; out_data=2048; in_ready=0 from the OUT cycle on; a 5th pair is not consumed.
3. N_IN=4, x=-256, w=512, bias=0 -> out_data=-2048 (0xFFFFF800). With DENSE_MAC_RELU_EN defined -> out_data=0.
4. OUT_W=16, N_IN=4, x=w=32767 -> out_data=32767, sat=1. With x=-32768, w=32767 -> out_data=-32768, sat=1.
5. bias=65536 (1.0 in product scale), N_IN=1, x=0, w=0 -> out_data=256. A start pulse during ACC of a running neuron -> ignored, and the result is unchanged.
6. Assert rst=0 after 2 of 4 pairs, release, start again with four pairs x=256, w=256 -> out_data=1024. Check that out_data=0, out_ld=0 and busy=0 during reset.
